// File: rtl/store_write_buffer.sv
// store_write_buffer
//   Small FIFO of pending stores sitting between the store pipe and data
//   memory. Each request is checked for width/alignment, formatted into
//   word address + lane-aligned data + byte enables, and queued. The head
//   entry is presented to memory until memory accepts it.
//
// Ports
//   i_clk, i_rst              clock, async active-high reset
//   i_storeValid/Addr/Data/Src store request (Src: 000 sb, 001 sh, 010 sw)
//   o_storeReady              room for a request (count < DEPTH)
//   o_memValid/Addr/WriteData/ByteEn  head entry to memory, zero when empty
//   i_memReady                memory takes the head entry this cycle
//   o_fault                   one-cycle pulse after a rejected request
//   o_count                   number of valid entries
module store_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_storeValid,
    input  logic [31:0]              i_storeAddr,
    input  logic [31:0]              i_storeData,
    input  logic [2:0]               i_storeSrc,
    output logic                     o_storeReady,
    output logic                     o_memValid,
    output logic [31:0]              o_memAddr,
    output logic [31:0]              o_memWriteData,
    output logic [3:0]               o_memByteEn,
    input  logic                     i_memReady,
    output logic                     o_fault,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CAP = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [29:0] wordAddr;
        logic [31:0] data;
        logic [3:0]  byteEn;
    } entry_t;

    // Storage is not reset; pointers and count alone define validity.
    entry_t entries [DEPTH];

    logic [PW-1:0] headPtr, tailPtr;
    logic [PW:0]   count;
    logic          fault;

    entry_t newEntry, headEntry;
    logic   legalWidth, aligned, offered, accept, reject, dequeue;

    // Request decode and lane formatting
    always_comb begin
        newEntry.wordAddr = i_storeAddr[31:2];
        newEntry.data     = i_storeData;
        newEntry.byteEn   = 4'b1111;
        legalWidth        = 1'b0;
        aligned           = 1'b0;
        case (i_storeSrc)
            3'b000: begin
                legalWidth      = 1'b1;
                aligned         = 1'b1;
                newEntry.data   = {4{i_storeData[7:0]}};
                newEntry.byteEn = 4'b0001 << i_storeAddr[1:0];
            end
            3'b001: begin
                legalWidth      = 1'b1;
                aligned         = ~i_storeAddr[0];
                newEntry.data   = {2{i_storeData[15:0]}};
                newEntry.byteEn = 4'b0011 << i_storeAddr[1:0];
            end
            3'b010: begin
                legalWidth      = 1'b1;
                aligned         = (i_storeAddr[1:0] == 2'b00);
            end
            default: ;
        endcase
    end

    // Ready comes from registered count only: a full buffer never takes a
    // request in the same cycle memory drains one.
    assign o_storeReady = (count < CAP);
    assign offered      = i_storeValid & o_storeReady;
    assign accept       = offered & legalWidth & aligned;
    assign reject       = offered & ~(legalWidth & aligned);
    assign o_memValid   = (count != '0);
    assign dequeue      = o_memValid & i_memReady;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            fault   <= 1'b0;
        end else begin
            fault <= reject;
            if (accept)  tailPtr <= tailPtr + PW'(1);
            if (dequeue) headPtr <= headPtr + PW'(1);
            case ({accept, dequeue})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) entries[tailPtr] <= newEntry;
    end

    assign headEntry      = entries[headPtr];
    assign o_memAddr      = o_memValid ? {headEntry.wordAddr, 2'b00} : 32'd0;
    assign o_memWriteData = o_memValid ? headEntry.data : 32'd0;
    assign o_memByteEn    = o_memValid ? headEntry.byteEn : 4'd0;
    assign o_fault        = fault;
    assign o_count        = count;

endmodule

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered store entries; power of two, >= 2.
REQ-002 Port: i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: i_rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: i_storeValid  input  1  store request present.
REQ-005 Port: i_storeAddr  input  32  byte address of store.
REQ-006 Port: i_storeData  input  32  store source data, right-justified.
REQ-007 Port: i_storeSrc  input  3  store width: 000 sb, 001 sh, 010 sw; all other codes illegal.
REQ-008 Port: o_storeReady  output  1  buffer can accept a request this cycle.
REQ-009 Port: o_memValid  output  1  head entry presented to data memory.
REQ-010 Port: o_memAddr  output  32  word address of head entry, bits [1:0] always 0.
REQ-011 Port: o_memWriteData  output  32  lane-aligned write data of head entry.
REQ-012 Port: o_memByteEn  output  4  byte-lane write enables of head entry; bit n enables bits [8n+7:8n].
REQ-013 Port: i_memReady  input  1  memory accepts head entry this cycle.
REQ-014 Port: o_fault  output  1  one-cycle pulse: last offered request rejected (misaligned or illegal width).
REQ-015 Port: o_count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 o_storeReady SHALL equal (o_count < DEPTH), combinationally from registered state only; no dependence on i_memReady (no full-buffer bypass).
REQ-017 A request is accepted when i_storeValid & o_storeReady & legal width & aligned; accepted entries are written at the tail at the rising edge.
REQ-018 Alignment: sb any address; sh requires addr[0]=0; sw requires addr[1:0]=00.
REQ-019 Formatting, with k = addr[1:0]: sb -> data {4{d[7:0]}}, byteEn 0001<<k; sh -> data {2{d[15:0]}}, byteEn 0011<<k; sw -> data d, byteEn 1111.
REQ-020 Stored address SHALL be {addr[31:2],2'b00}.
REQ-021 Rejected request (i_storeValid & o_storeReady & (misaligned | illegal width)): not enqueued, state unchanged except o_fault=1 for exactly the following cycle.
REQ-022 Request offered while o_storeReady=0: neither enqueued nor faulted; requester holds it.
REQ-023 o_memValid SHALL equal (o_count != 0); o_memAddr/o_memWriteData/o_memByteEn show head entry, all zero when empty.
REQ-024 Head dequeued at rising edge when o_memValid & i_memReady; outputs held stable while o_memValid=1 and i_memReady=0.
REQ-025 Latency: entry accepted at edge N appears on memory outputs after edge N if buffer was empty; no same-cycle passthrough.
REQ-026 Strict FIFO order; head/tail pointers wrap modulo DEPTH.
REQ-027 Simultaneous accept and dequeue: count unchanged, both pointers advance.
REQ-028 i_memReady while empty: ignored, no state change.

Reset
REQ-029 On i_rst assertion, immediately and independent of i_clk: pointers 0, o_count 0, o_memValid 0, o_fault 0, memory outputs 0, o_storeReady 1.
REQ-030 Reset mid-operation discards all buffered entries; no pending store is issued after reset deasserts.
REQ-031 Storage array contents need not be reset.

Verification
REQ-032 sb addr 0x1003 data 0x000000A5, memReady=1 -> next cycle memValid=1, memAddr 0x1000, data 0xA5A5A5A5, byteEn 1000; entry gone after that edge.
REQ-033 sh addr 0x2002 data 0x1234BEEF -> data 0xBEEFBEEF, byteEn 1100; sw addr 0x2001 -> o_fault pulse 1 cycle, count unchanged.
REQ-034 memReady=0, 4 sw stores -> count 4, storeReady 0; 5th request held, no fault; release memReady -> 4 entries drain in order, one per cycle.
REQ-035 At count 4, storeReady=0 while memReady=1 -> count 3 next cycle; then accept+dequeue same cycle -> count stays 3, wrap of tail pointer verified.
REQ-036 i_storeSrc=011 aligned -> o_fault pulse, no enqueue; i_rst asserted with 3 entries mid-cycle -> memValid 0 and count 0 before next clock edge.
